// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: HSYNC/VSYNC, active-video qualifier, pixel coordinates
// and line/frame strobes, advanced by a pixel-clock enable, with an optional sync/valid delay line.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned SYNC_DLY = 0,
    parameter int unsigned COL_W    = 10,
    parameter int unsigned ROW_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             valid,
    output logic [COL_W-1:0] curr_col,
    output logic [ROW_W-1:0] curr_row,
    output logic             frame_start,
    output logic             line_start
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEGIN = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_BEGIN = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic        HS_ACT   = (HS_POL != 0);
    localparam logic        VS_ACT   = (VS_POL != 0);
    localparam int unsigned DW       = 3 * (SYNC_DLY + 1);
    localparam logic [2:0]  IDLE     = {~HS_ACT, ~VS_ACT, 1'b0};

    logic [COL_W-1:0] r_h_cnt;
    logic [ROW_W-1:0] r_v_cnt;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_line_start;
    logic             r_frame_start;
    // Packed {hsync, vsync, valid} per stage; stage 0 in the low bits, output stage at the top.
    logic [DW-1:0]    r_dly;

    logic [31:0]      w_h;
    logic [31:0]      w_v;
    logic             w_active;
    logic             w_hs_on;
    logic             w_vs_on;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [2:0]       w_stage0;

    assign w_h      = 32'(r_h_cnt);
    assign w_v      = 32'(r_v_cnt);
    assign w_active = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    assign w_hs_on  = (w_h >= HS_BEGIN) && (w_h < HS_END);
    assign w_vs_on  = (w_v >= VS_BEGIN) && (w_v < VS_END);
    assign w_h_wrap = (w_h == H_TOTAL - 1);
    assign w_v_wrap = (w_v == V_TOTAL - 1);
    assign w_stage0 = {(w_hs_on ? HS_ACT : ~HS_ACT), (w_vs_on ? VS_ACT : ~VS_ACT), w_active};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_dly         <= {(SYNC_DLY + 1){IDLE}};
        end else if (pix_en) begin
            r_col         <= r_h_cnt;
            r_row         <= r_v_cnt;
            r_line_start  <= (r_h_cnt == '0);
            r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
            r_dly         <= DW'({r_dly, w_stage0});
            if (w_h_wrap) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + ROW_W'(1);
            end else begin
                r_h_cnt <= r_h_cnt + COL_W'(1);
            end
        end
    end

    assign {HSYNC, VSYNC, valid} = r_dly[DW-1 -: 3];
    assign curr_col    = r_col;
    assign curr_row    = r_row;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default, small-raster and delayed-sync instances
// checked against a frame-index reference model, a vector table and timing measurements.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [15:0] col;
        logic [15:0] row;
        logic fs;
        logic ls;
        logic hs;
        logic vs;
        logic val;
    } obs_t;

    typedef struct packed {
        logic rst_n;
        logic pe;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Raster configurations: 0 = defaults, 1 = small raster, 2 = delayed syncs
    int    cha [3] = '{640, 8, 16};
    int    chf [3] = '{16, 1, 2};
    int    chs [3] = '{96, 2, 4};
    int    chb [3] = '{48, 1, 3};
    int    cva [3] = '{480, 4, 10};
    int    cvf [3] = '{10, 1, 2};
    int    cvs [3] = '{2, 1, 2};
    int    cvb [3] = '{33, 1, 3};
    logic  chp [3] = '{1'b0, 1'b1, 1'b0};
    logic  cvp [3] = '{1'b0, 1'b1, 1'b0};
    int    cdly[3] = '{0, 0, 2};
    string names[3] = '{"dflt", "small", "dly2"};

    logic       hs0, vs0, val0, fs0, ls0;
    logic [9:0] col0, row0;
    logic       hs1, vs1, val1, fs1, ls1;
    logic [3:0] col1;
    logic [2:0] row1;
    logic       hs2, vs2, val2, fs2, ls2;
    logic [4:0] col2, row2;

    vga_timing_gen u_dflt (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .HSYNC(hs0), .VSYNC(vs0), .valid(val0),
        .curr_col(col0), .curr_row(row0), .frame_start(fs0), .line_start(ls0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .SYNC_DLY(0), .COL_W(4), .ROW_W(3)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .HSYNC(hs1), .VSYNC(vs1), .valid(val1),
        .curr_col(col1), .curr_row(row1), .frame_start(fs1), .line_start(ls1)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(0), .VS_POL(0), .SYNC_DLY(2), .COL_W(5), .ROW_W(5)
    ) u_dly (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .HSYNC(hs2), .VSYNC(vs2), .valid(val2),
        .curr_col(col2), .curr_row(row2), .frame_start(fs2), .line_start(ls2)
    );

    // Reference model: linear pixel index within the frame, plus a history of decoded sync/valid.
    int         m_k[3];
    obs_t       m_cur[3];
    logic [2:0] m_hist[3][9];

    function automatic obs_t decode(int d, int k);
        obs_t o;
        int ht, h, v;
        ht = cha[d] + chf[d] + chs[d] + chb[d];
        h = k % ht;
        v = k / ht;
        o.col = 16'(h);
        o.row = 16'(v);
        o.val = (h < cha[d]) && (v < cva[d]);
        o.hs  = ((h >= cha[d] + chf[d]) && (h < cha[d] + chf[d] + chs[d])) ? chp[d] : !chp[d];
        o.vs  = ((v >= cva[d] + cvf[d]) && (v < cva[d] + cvf[d] + cvs[d])) ? cvp[d] : !cvp[d];
        o.ls  = (h == 0);
        o.fs  = (k == 0);
        return o;
    endfunction

    task automatic model_edge(int d, logic r, logic pe);
        obs_t e;
        int frame;
        frame = (cha[d] + chf[d] + chs[d] + chb[d]) * (cva[d] + cvf[d] + cvs[d] + cvb[d]);
        if (!r) begin
            m_k[d] = 0;
            m_cur[d] = '0;
            for (int i = 0; i < 9; i++) m_hist[d][i] = {!chp[d], !cvp[d], 1'b0};
        end else if (pe) begin
            e = decode(d, m_k[d]);
            m_cur[d] = e;
            for (int i = 8; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
            m_hist[d][0] = {e.hs, e.vs, e.val};
            m_k[d] = (m_k[d] + 1) % frame;
        end
    endtask

    function automatic obs_t expected(int d);
        obs_t o;
        o = m_cur[d];
        {o.hs, o.vs, o.val} = m_hist[d][cdly[d]];
        return o;
    endfunction

    function automatic obs_t actual(int d);
        obs_t o;
        o = '0;
        case (d)
            0: begin o.col = 16'(col0); o.row = 16'(row0); {o.fs, o.ls, o.hs, o.vs, o.val} = {fs0, ls0, hs0, vs0, val0}; end
            1: begin o.col = 16'(col1); o.row = 16'(row1); {o.fs, o.ls, o.hs, o.vs, o.val} = {fs1, ls1, hs1, vs1, val1}; end
            default: begin o.col = 16'(col2); o.row = 16'(row2); {o.fs, o.ls, o.hs, o.vs, o.val} = {fs2, ls2, hs2, vs2, val2}; end
        endcase
        return o;
    endfunction

    task automatic check_obs(string name, obs_t a, obs_t e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got col=%0d row=%0d fs=%b ls=%b hs=%b vs=%b val=%b, expected col=%0d row=%0d fs=%b ls=%b hs=%b vs=%b val=%b",
                     name, a.col, a.row, a.fs, a.ls, a.hs, a.vs, a.val, e.col, e.row, e.fs, e.ls, e.hs, e.vs, e.val);
        end
    endtask

    task automatic check(string name, int a, int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, a, e);
        end
    endtask

    task automatic step(logic r, logic pe);
        rst_n = r;
        pix_en = pe;
        @(posedge clk);
        for (int d = 0; d < 3; d++) model_edge(d, r, pe);
        #1;
        for (int d = 0; d < 3; d++) check_obs({"model_", names[d]}, actual(d), expected(d));
    endtask

    function automatic vec_t mkv(logic r, logic pe, int col, int row, logic hs, logic vs, logic val, logic fs, logic ls);
        vec_t v;
        v.rst_n = r;
        v.pe = pe;
        v.exp.col = 16'(col);
        v.exp.row = 16'(row);
        {v.exp.fs, v.exp.ls, v.exp.hs, v.exp.vs, v.exp.val} = {fs, ls, hs, vs, val};
        return v;
    endfunction

    initial begin
        vec_t tbl[23];
        int cnt_val, cnt_hs, hs_first, hs_last, ls_a, ls_b, fs_a, fs_b, vs_cnt, vs_row, shs_cnt, c11, c12;
        logic ls_prev;

        // Small raster (HS/VS active-high): reset, enable holds, HSYNC at 9..10, wrap 11->0
        for (int i = 0; i < 5; i++) tbl[i] = mkv(1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mkv(1'b1, 1'b1, 0, 0, 0, 0, 1, 1, 1);
        tbl[6]  = mkv(1'b1, 1'b1, 1, 0, 0, 0, 1, 0, 0);
        tbl[7]  = mkv(1'b1, 1'b0, 1, 0, 0, 0, 1, 0, 0);
        tbl[8]  = mkv(1'b1, 1'b1, 2, 0, 0, 0, 1, 0, 0);
        tbl[9]  = mkv(1'b1, 1'b0, 2, 0, 0, 0, 1, 0, 0);
        for (int i = 10; i < 15; i++) tbl[i] = mkv(1'b1, 1'b1, i - 7, 0, 0, 0, 1, 0, 0);
        tbl[15] = mkv(1'b1, 1'b1, 8, 0, 0, 0, 0, 0, 0);
        tbl[16] = mkv(1'b1, 1'b1, 9, 0, 1, 0, 0, 0, 0);
        tbl[17] = mkv(1'b1, 1'b1, 10, 0, 1, 0, 0, 0, 0);
        tbl[18] = mkv(1'b1, 1'b1, 11, 0, 0, 0, 0, 0, 0);
        tbl[19] = mkv(1'b1, 1'b1, 0, 1, 0, 0, 1, 0, 1);
        tbl[20] = mkv(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        tbl[21] = mkv(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        tbl[22] = mkv(1'b1, 1'b1, 0, 0, 0, 0, 1, 1, 1);

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].rst_n, tbl[i].pe);
            check_obs($sformatf("tbl[%0d]", i), actual(1), tbl[i].exp);
            if (i == 4) begin
                check("rst_dflt_hsync", int'(hs0), 1);
                check("rst_dflt_vsync", int'(vs0), 1);
                check("rst_dflt_valid", int'(val0), 0);
            end
        end

        // Continuous enable: line-0 timing of defaults, small-raster frame timing
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        cnt_val = 0; cnt_hs = 0; hs_first = -1; hs_last = -1; ls_a = -1; ls_b = -1;
        fs_a = -1; fs_b = -1; vs_cnt = 0; vs_row = -1; shs_cnt = 0; c11 = -1; c12 = -1;
        for (int i = 0; i < 1700; i++) begin
            step(1'b1, 1'b1);
            if (i < 800) begin
                if (val0) cnt_val++;
                if (!hs0) begin
                    cnt_hs++;
                    if (hs_first < 0) hs_first = int'(col0);
                    hs_last = int'(col0);
                end
            end
            if (ls0) begin
                if (ls_a < 0) ls_a = i;
                else if (ls_b < 0) ls_b = i;
            end
            if (fs1) begin
                if (fs_a < 0) fs_a = i;
                else if (fs_b < 0) fs_b = i;
            end
            if (i < 84 && vs1) begin
                vs_cnt++;
                if (vs_row < 0) vs_row = int'(row1);
            end
            if (i < 12 && hs1) shs_cnt++;
            if (i == 11) c11 = int'(col1);
            if (i == 12) c12 = int'(col1);
        end
        check("line0_valid_clks", cnt_val, 640);
        check("line0_hsync_clks", cnt_hs, 96);
        check("line0_hsync_first_col", hs_first, 656);
        check("line0_hsync_last_col", hs_last, 751);
        check("line_start_period", ls_b - ls_a, 800);
        check("small_frame_period", fs_b - fs_a, 84);
        check("small_vsync_clks", vs_cnt, 12);
        check("small_vsync_row", vs_row, 5);
        check("small_hsync_clks", shs_cnt, 2);
        check("small_col_before_wrap", c11, 11);
        check("small_col_after_wrap", c12, 0);

        // Half-rate enable: every timing doubles
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        ls_prev = 1'b0; ls_a = -1; ls_b = -1; cnt_val = 0;
        for (int i = 0; i < 3400; i++) begin
            step(1'b1, (i % 2) == 0);
            if (ls0 && !ls_prev) begin
                if (ls_a < 0) ls_a = i;
                else if (ls_b < 0) ls_b = i;
            end
            ls_prev = ls0;
            if (i < 1600 && val0) cnt_val++;
        end
        check("halfrate_line_period", ls_b - ls_a, 1600);
        check("halfrate_valid_clks", cnt_val, 1280);

        // Mid-frame reset on the delayed instance: strobe immediately, syncs inactive for 2 edges
        step(1'b0, 1'b1);
        for (int i = 0; i < 200; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)));
        step(1'b1, 1'b1);
        check("dly_rel1_frame_start", int'(fs2), 1);
        check("dly_rel1_col", int'(col2), 0);
        check("dly_rel1_valid", int'(val2), 0);
        check("dly_rel1_hsync", int'(hs2), 1);
        step(1'b1, 1'b1);
        check("dly_rel2_valid", int'(val2), 0);
        check("dly_rel2_hsync", int'(hs2), 1);
        step(1'b1, 1'b1);
        check("dly_rel3_valid", int'(val2), 1);
        check("dly_rel3_col", int'(col2), 2);

        // Randomised enable and occasional resets against the model
        for (int i = 0; i < 20000; i++) begin
            step(($urandom_range(0, 4999) == 0) ? 1'b0 : 1'b1, ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
